// File: rtl/add_accum_pkg.sv
// add_accum_pkg
//   Shared types and helpers for the add_accum block.
//   - add_accum_state_t : frame FSM states (ACCUM collects pairs, HOLD presents a total)
//   - acc_width(dw, n)  : width needed to sum n values of (dw+1) bits without overflow
package add_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } add_accum_state_t;

  function automatic int acc_width(input int dw, input int n);
    return dw + 1 + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/add_accum_if.sv
// add_accum_if
//   Operand/result bus for add_accum.
//   Input side : in_valid/in_ready handshake with operands in_a, in_b, plus flush.
//   Sum side   : sum_valid pulse with registered sum.
//   Output side: out_valid/out_ready handshake with out_total, out_count, out_max.
//   Modports   : master = operand source / result sink, slave = add_accum.
interface add_accum_if
  import add_accum_pkg::*;
#(
  parameter int DW        = 4,
  parameter int N_SAMPLES = 11
);
  localparam int ACC_W = acc_width(DW, N_SAMPLES);
  localparam int CW    = $clog2(N_SAMPLES + 1);

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic             flush;
  logic             sum_valid;
  logic [DW:0]      sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [CW-1:0]    out_count;
  logic [DW:0]      out_max;

  modport master (
    output in_valid, in_a, in_b, flush, out_ready,
    input  in_ready, sum_valid, sum, out_valid, out_total, out_count, out_max
  );

  modport slave (
    input  in_valid, in_a, in_b, flush, out_ready,
    output in_ready, sum_valid, sum, out_valid, out_total, out_count, out_max
  );

endinterface

// File: rtl/add_accum_add_stage.sv
// add_stage
//   Registered adder: when en is high, sum takes in_a + in_b (zero-extended,
//   never wraps) and sum_valid pulses for one cycle. sum holds between pulses.
//   Ports: clk, rst (async active-high), en, in_a[DW], in_b[DW] -> sum[DW+1], sum_valid.
module add_stage #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic [DW:0]   sum,
  output logic          sum_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= en;
      if (en) sum <= {1'b0, in_a} + {1'b0, in_b};
    end
  end

endmodule

// File: rtl/add_accum.sv
// add_accum
//   Accepts operand pairs, presents each registered pair sum, and accumulates
//   N_SAMPLES sums (or fewer, on flush) into a frame total handed off on a
//   valid/ready output.
//   Ports: clk, rst (async active-high), bus (add_accum_if.slave).
//   Build option: define ADD_ACCUM_MAX_EN to track the per-frame maximum pair
//   sum on out_max; otherwise out_max is tied to 0.
module add_accum
  import add_accum_pkg::*;
#(
  parameter int DW        = 4,
  parameter int N_SAMPLES = 11
) (
  input logic         clk,
  input logic         rst,
  add_accum_if.slave  bus
);
  localparam int ACC_W = acc_width(DW, N_SAMPLES);
  localparam int CW    = $clog2(N_SAMPLES + 1);

  add_accum_state_t state, state_next;

  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] out_total_r;
  logic [CW-1:0]    out_count_r;
  logic             out_valid_r;

  logic             in_ready;
  logic             accept;
  logic             close;
  logic [DW:0]      s;
  logic [ACC_W-1:0] acc_sum;
  logic [CW-1:0]    cnt_next;

  // in_ready depends on state alone, so there is no in_valid -> in_ready path.
  assign in_ready = (state == ACCUM);
  assign accept   = bus.in_valid & in_ready;
  assign s        = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign acc_sum  = acc + (accept ? ACC_W'(s) : '0);
  assign cnt_next = cnt + CW'(accept);

  // A frame closes on its last pair, or on flush when it would hold at least
  // one pair (an empty flush is dropped rather than emitting an empty frame).
  assign close = in_ready &&
                 ((accept && (cnt == CW'(N_SAMPLES - 1))) ||
                  (bus.flush && (accept || (cnt != '0))));

  add_stage #(.DW(DW)) u_add_stage (
    .clk       (clk),
    .rst       (rst),
    .en        (accept),
    .in_a      (bus.in_a),
    .in_b      (bus.in_b),
    .sum       (bus.sum),
    .sum_valid (bus.sum_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (close) state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // The accumulator is cleared on hand-off, so the next frame starts the
  // cycle after out_ready with no extra bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      out_total_r <= '0;
      out_count_r <= '0;
      out_valid_r <= 1'b0;
    end else if (state == HOLD) begin
      if (bus.out_ready) begin
        out_valid_r <= 1'b0;
        acc         <= '0;
        cnt         <= '0;
      end
    end else begin
      if (accept) begin
        acc <= acc_sum;
        cnt <= cnt_next;
      end
      if (close) begin
        out_total_r <= acc_sum;
        out_count_r <= cnt_next;
        out_valid_r <= 1'b1;
      end
    end
  end

`ifdef ADD_ACCUM_MAX_EN
  logic [DW:0] max_r;
  logic [DW:0] max_next;
  logic [DW:0] out_max_r;

  assign max_next = (accept && (s > max_r)) ? s : max_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_r     <= '0;
      out_max_r <= '0;
    end else if (state == HOLD) begin
      if (bus.out_ready) max_r <= '0;
    end else begin
      if (accept) max_r <= max_next;
      if (close)  out_max_r <= max_next;
    end
  end

  assign bus.out_max = out_max_r;
`else
  assign bus.out_max = '0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.out_total = out_total_r;
  assign bus.out_count = out_count_r;

endmodule

// File: tb/tb_add_accum.sv
// tb_add_accum
//   Self-checking bench for add_accum. A frame-level reference model (a queue
//   of accepted pair sums) predicts every output one cycle after each stimulus.
module tb_add_accum;
  import add_accum_pkg::*;

  localparam int DW = 4;
  localparam int N  = 11;

  logic clk = 1'b0;
  logic rst;

  add_accum_if #(.DW(DW), .N_SAMPLES(N)) bus ();

  add_accum #(.DW(DW), .N_SAMPLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit m_hold;
  int m_q[$];
  int m_sum;
  bit m_sum_valid;
  bit m_out_valid;
  int m_total;
  int m_count;
  int m_max;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_hold      = 1'b0;
    m_q.delete();
    m_sum       = 0;
    m_sum_valid = 1'b0;
    m_out_valid = 1'b0;
    m_total     = 0;
    m_count     = 0;
    m_max       = 0;
  endtask

  task automatic checkAll(input string tag, input bit full);
    checkOutput({tag, "_in_ready"},  32'(bus.in_ready),  32'(!m_hold));
    checkOutput({tag, "_sum_valid"}, 32'(bus.sum_valid), 32'(m_sum_valid));
    checkOutput({tag, "_sum"},       32'(bus.sum),       m_sum);
    checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'(m_out_valid));
    if (full || m_out_valid) begin
      checkOutput({tag, "_out_total"}, 32'(bus.out_total), m_total);
      checkOutput({tag, "_out_count"}, 32'(bus.out_count), m_count);
      checkOutput({tag, "_out_max"},   32'(bus.out_max),   m_max);
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model by
  // the rules of the frame protocol, then check at the next falling edge.
  task automatic applyStimulus(input bit v, input int a, input int b,
                               input bit f, input bit r, input string tag);
    bit acc_ok;
    bus.in_valid  = v;
    bus.in_a      = 4'(a);
    bus.in_b      = 4'(b);
    bus.flush     = f;
    bus.out_ready = r;

    acc_ok      = v && !m_hold;
    m_sum_valid = acc_ok;
    if (acc_ok) m_sum = a + b;
    if (m_hold) begin
      if (r) begin
        m_hold      = 1'b0;
        m_out_valid = 1'b0;
        m_q.delete();
      end
    end else begin
      if (acc_ok) m_q.push_back(a + b);
      if ((acc_ok && m_q.size() == N) || (f && m_q.size() > 0)) begin
        m_total = m_q.sum();
        m_count = m_q.size();
        m_max   = 0;
`ifdef ADD_ACCUM_MAX_EN
        foreach (m_q[i]) if (m_q[i] > m_max) m_max = m_q[i];
`endif
        m_hold      = 1'b1;
        m_out_valid = 1'b1;
      end
    end

    @(posedge clk);
    @(negedge clk);
    checkAll(tag, 1'b0);
  endtask

  initial begin
    int exp_max;
`ifdef ADD_ACCUM_MAX_EN
    exp_max = 30;
`else
    exp_max = 0;
`endif

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset", 1'b1);
    rst = 1'b0;

    // Reset asserted between edges in the middle of a frame
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0, 1'b1, "t1_pre");
    #5 rst = 1'b1;
    #1;
    modelReset();
    checkAll("t1_async_rst", 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      applyStimulus(1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0, 1'b1, "t1_frame");
    checkOutput("t1_count", 32'(bus.out_count), 11);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, "t1_release");

    // Maximum operands for a full frame
    for (int i = 0; i < N; i++)
      applyStimulus(1'b1, 15, 15, 1'b0, 1'b1, "t2_pair");
    checkOutput("t2_total", 32'(bus.out_total), 330);
    checkOutput("t2_count", 32'(bus.out_count), 11);
    checkOutput("t2_max",   32'(bus.out_max),   exp_max);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, "t2_release");

    // Flush on the third accepted pair
    applyStimulus(1'b1, 1, 2, 1'b0, 1'b1, "t3_p1");
    applyStimulus(1'b1, 3, 4, 1'b0, 1'b1, "t3_p2");
    applyStimulus(1'b1, 0, 0, 1'b1, 1'b1, "t3_p3");
    checkOutput("t3_total", 32'(bus.out_total), 10);
    checkOutput("t3_count", 32'(bus.out_count), 3);
`ifdef ADD_ACCUM_MAX_EN
    checkOutput("t3_max", 32'(bus.out_max), 7);
`else
    checkOutput("t3_max", 32'(bus.out_max), 0);
`endif
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, "t3_release");

    // Back-pressure: total held, inputs refused, then resume
    for (int i = 0; i < N; i++)
      applyStimulus(1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0, 1'b0, "t4_frame");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0, 1'b0, "t4_stall");
    applyStimulus(1'b1, 5, 6, 1'b0, 1'b1, "t4_release");
    checkOutput("t4_in_ready_after", 32'(bus.in_ready), 1);

    // Empty flush, then flush while holding
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, "t5_empty_flush");
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, "t5_flush_one");
    applyStimulus(1'b1, 9, 8, 1'b1, 1'b0, "t5_flush_two");
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, "t5_hold_flush_a");
    applyStimulus(1'b1, 7, 7, 1'b1, 1'b0, "t5_hold_flush_b");
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, "t5_release");

    // Random traffic
    for (int i = 0; i < 120; i++) begin
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, "t6_rand");
      checkOutput("t6_sum_le30", 32'(bus.sum <= 5'd30), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
